game_datapath: RTL and testbench

- Datapath half of the memory game; executes the controller's commands and returns its status flags.
- Commands: r1, r2, e1, e2, e3, e4, sel. Status flags: end_fpga, end_user, end_time, win, match.
- Holds the random sequence, shows it on the LEDs, captures and checks the user's key presses, runs the round timeout, and keeps the round and score counts.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_datapath_lfsr16.sv | 33 +++
 rtl/game_datapath.sv | 229 ++++++++++++++++++++++
 tb/tb_game_datapath.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and helpers for the memory-game datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   N_ROUNDS_DEF - default number of rounds in a full game
//   KEY_W        - width of the key / LED buses
//   LFSR_SEED    - value the sequence generator restarts from on async reset
//   LFSR_TAPS    - feedback mask for taps 16,14,13,11 (bit positions 15,13,12,10)
//   key_onehot() - maps a 2-bit sequence element to its one-hot key/LED pattern
package game_pkg;

  localparam int N_ROUNDS_DEF = 16;
  localparam int KEY_W        = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [KEY_W-1:0] key_onehot(input logic [1:0] v);
    return {{(KEY_W-1){1'b0}}, 1'b1} << v;
  endfunction

endpackage

// File: rtl/game_datapath_lfsr16.sv
// 16-bit Fibonacci LFSR that free-runs every cycle; supplies random pairs.
// Latency: new value every clock; output is the current register value.
// Backpressure: none, it never stalls; only the async reset reseeds it.
//
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high, reloads LFSR_SEED
//   o_lfsr - current 16-bit LFSR state
module lfsr16
  import game_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Shift toward the MSB; the XOR of the tapped bits enters at bit 0.
  assign w_fb = ^(r_lfsr & LFSR_TAPS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/game_datapath.sv
// Memory-game datapath: sequence store/display, key capture and checking, timeout, round/score.
// Latency: status flags are registered (visible the cycle after the causing edge); match/win/leds/hex are combinational.
// Backpressure: none; the controller sequences commands and reads the status flags directly.
//
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   r1, r2              - game reset / round reset commands (r1 has priority)
//   e1, e2, e3, e4      - setup, user-play, FPGA-play and check enables (at most one at a time)
//   sel                 - hex_value select: 1 = score, 0 = round number (1-based)
//   keys                - debounced one-cycle key pulses
//   sw_level            - difficulty switches, latched during setup
//   end_fpga, end_user, end_time - sticky per-round status flags, cleared by r2
//   win, match          - last round reached / user entry correct
//   leds                - one-hot LED drive (sequence display or key echo)
//   hex_value           - binary value for the external 7-segment decoder
module game_datapath
  import game_pkg::*;
#(
  parameter int N_ROUNDS     = N_ROUNDS_DEF,
  parameter int DISP_TICKS   = 25_000_000,
  parameter int GAP_TICKS    = 12_500_000,
  parameter int BASE_TIMEOUT = 250_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r1,
  input  logic             r2,
  input  logic             e1,
  input  logic             e2,
  input  logic             e3,
  input  logic             e4,
  input  logic             sel,
  input  logic [KEY_W-1:0] keys,
  input  logic [1:0]       sw_level,
  output logic             end_fpga,
  output logic             end_user,
  output logic             end_time,
  output logic             win,
  output logic             match,
  output logic [KEY_W-1:0] leds,
  output logic [7:0]       hex_value
);

  // Sizing. N_ROUNDS must be at least 2; GAP_TICKS at least 1.
  localparam int SEQ_W  = 2 * N_ROUNDS;
  localparam int RND_W  = $clog2(N_ROUNDS);
  localparam int IDX_W  = $clog2(N_ROUNDS + 1);
  localparam int ELEM_T = DISP_TICKS + GAP_TICKS;
  localparam int TCK_W  = $clog2(ELEM_T);
  localparam int TMR_W  = $clog2(BASE_TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMO_BASE = TMR_W'(BASE_TIMEOUT);
  localparam logic [TCK_W-1:0] TCK_DISP = TCK_W'(DISP_TICKS);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(ELEM_T - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(N_ROUNDS - 1);

  // ------------------------------------------------------------------
  // Random source
  // ------------------------------------------------------------------
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  // Only the two low bits feed the sequence.
  assign w_unused_lfsr = ^w_lfsr[15:2];

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  // Element i of the sequence lives in r_seq[2i+1:2i]; element 0 is the
  // pair shifted in last during setup.
  logic [SEQ_W-1:0] r_seq;
  logic [1:0]       r_level;
  logic [RND_W-1:0] r_round;
  logic [7:0]       r_score;

  logic [IDX_W-1:0] r_fpga_idx;
  logic [IDX_W-1:0] r_user_idx;
  logic [TCK_W-1:0] r_tick;
  logic [TMR_W-1:0] r_timer;
  logic             r_err;
  logic             r_end_fpga;
  logic             r_end_user;
  logic             r_end_time;

  logic             w_play;
  logic [IDX_W-1:0] w_target;
  logic [1:0]       w_fpga_elem;
  logic [1:0]       w_user_elem;
  logic             w_key_vld;
  logic [TMR_W-1:0] w_limit;
  logic             w_match;

  // Enables are only honoured when no reset command is present.
  assign w_play = ~r1 & ~r2;

  // Number of elements in the current round.
  assign w_target = IDX_W'(r_round) + IDX_W'(1);

  // Timeout halves with each difficulty level.
  assign w_limit = TMO_BASE >> r_level;

  // Any nonzero key pattern is a press; presses after the round is
  // complete, or outside user play, are dropped.
  assign w_key_vld = w_play & e2 & ~r_end_user & (|keys);

  // Element lookup for the display pointer and the user pointer. Pointers
  // can reach N_ROUNDS (one past the last element); those cycles are gated
  // by the end flags, so the mux default is never shown.
  always_comb begin
    w_fpga_elem = 2'd0;
    w_user_elem = 2'd0;
    for (int i = 0; i < N_ROUNDS; i++) begin
      if (r_fpga_idx == IDX_W'(i)) w_fpga_elem = r_seq[2*i +: 2];
      if (r_user_idx == IDX_W'(i)) w_user_elem = r_seq[2*i +: 2];
    end
  end

  // ------------------------------------------------------------------
  // Game-level state: sequence, level, round, score
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seq   <= '0;
      r_level <= 2'd0;
      r_round <= '0;
      r_score <= 8'd0;
    end else if (r1) begin
      r_seq   <= '0;
      r_level <= 2'd0;
      r_round <= '0;
      r_score <= 8'd0;
    end else if (r2) begin
      if (r_round != RND_LAST) r_round <= r_round + RND_W'(1);
    end else begin
      if (e1) begin
        // Setup length decides which LFSR pairs end up in the sequence.
        r_level <= sw_level;
        r_seq   <= {r_seq[SEQ_W-3:0], w_lfsr[1:0]};
      end
      if (e4 && w_match && (r_score != 8'hFF)) begin
        r_score <= r_score + 8'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-round state: display, key capture, timeout
  // r2 clears it even when r1 is also asserted, so r1+r2 together starts
  // a fresh game at round 0 with clean counters.
  // ------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fpga_idx <= '0;
      r_user_idx <= '0;
      r_tick     <= '0;
      r_timer    <= '0;
      r_err      <= 1'b0;
      r_end_fpga <= 1'b0;
      r_end_user <= 1'b0;
      r_end_time <= 1'b0;
    end else if (r2) begin
      r_fpga_idx <= '0;
      r_user_idx <= '0;
      r_tick     <= '0;
      r_timer    <= '0;
      r_err      <= 1'b0;
      r_end_fpga <= 1'b0;
      r_end_user <= 1'b0;
      r_end_time <= 1'b0;
    end else if (!r1) begin
      // Sequence display: DISP_TICKS lit, GAP_TICKS dark per element.
      if (e3 && !r_end_fpga) begin
        if (r_tick == TCK_LAST) begin
          r_tick     <= '0;
          r_fpga_idx <= r_fpga_idx + IDX_W'(1);
          if ((r_fpga_idx + IDX_W'(1)) >= w_target) r_end_fpga <= 1'b1;
        end else begin
          r_tick <= r_tick + TCK_W'(1);
        end
      end

      if (e2) begin
        // Timer parks once the limit is reached; the flag then holds.
        if (!r_end_time) begin
          r_timer <= r_timer + TMR_W'(1);
          if ((r_timer + TMR_W'(1)) >= w_limit) r_end_time <= 1'b1;
        end
        // Key capture is independent of the timeout, so a press on the
        // limit cycle still counts.
        if (w_key_vld) begin
          if (keys != key_onehot(w_user_elem)) r_err <= 1'b1;
          r_user_idx <= r_user_idx + IDX_W'(1);
          if ((r_user_idx + IDX_W'(1)) >= w_target) r_end_user <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign w_match   = r_end_user & ~r_err;
  assign match     = w_match;
  assign win       = (r_round == RND_LAST);
  assign end_fpga  = r_end_fpga;
  assign end_user  = r_end_user;
  assign end_time  = r_end_time;
  assign hex_value = sel ? r_score : (8'(r_round) + 8'd1);

  // LEDs are combinational; forced dark while reset is held so an async
  // reset blanks them immediately even if an enable is still high.
  always_comb begin
    leds = '0;
    if (!reset && w_play) begin
      if (e3 && !r_end_fpga && (r_tick < TCK_DISP)) begin
        leds = key_onehot(w_fpga_elem);
      end else if (w_key_vld) begin
        leds = keys;
      end
    end
  end

endmodule

// File: tb/tb_game_datapath.sv
module tb_game_datapath;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int G  = 2;
  localparam int BT = 100;
  localparam int ET = D + G;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       r1       = 1'b0;
  logic       r2       = 1'b0;
  logic       e1       = 1'b0;
  logic       e2       = 1'b0;
  logic       e3       = 1'b0;
  logic       e4       = 1'b0;
  logic       sel      = 1'b0;
  logic [3:0] keys     = 4'd0;
  logic [1:0] sw_level = 2'd0;
  logic       end_fpga, end_user, end_time, win, match;
  logic [3:0] leds;
  logic [7:0] hex_value;

  game_datapath #(
    .N_ROUNDS     (N),
    .DISP_TICKS   (D),
    .GAP_TICKS    (G),
    .BASE_TIMEOUT (BT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .r1        (r1),
    .r2        (r2),
    .e1        (e1),
    .e2        (e2),
    .e3        (e3),
    .e4        (e4),
    .sel       (sel),
    .keys      (keys),
    .sw_level  (sw_level),
    .end_fpga  (end_fpga),
    .end_user  (end_user),
    .end_time  (end_time),
    .win       (win),
    .match     (match),
    .leds      (leds),
    .hex_value (hex_value)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------------------
  // Behavioural model: counts of events since the last round reset,
  // plus the full history of setup pairs.
  // ----------------------------------------------------------------
  logic [15:0] m_lfsr  = 16'hACE1;
  int          m_hist[$];
  int          m_round = 0;
  int          m_score = 0;
  int          m_level = 0;
  int          m_fc    = 0;   // e3 cycles spent displaying this round
  int          m_tc    = 0;   // e2 cycles this round
  int          m_press = 0;   // accepted key presses this round
  bit          m_err   = 0;
  bit          m_ef    = 0;
  bit          m_eu    = 0;
  bit          m_et    = 0;
  bit          chk_on  = 0;

  // Element 0 is the newest setup pair; missing elements read as 0.
  function automatic int elem(input int i);
    if (i < m_hist.size()) return m_hist[m_hist.size() - 1 - i];
    return 0;
  endfunction

  function automatic logic [3:0] oh(input int v);
    return 4'b0001 << v;
  endfunction

  function automatic bit x_match();
    return m_eu && !m_err;
  endfunction

  function automatic logic [3:0] x_leds();
    if (reset || r1 || r2) return 4'b0000;
    if (e3 && !m_ef) return ((m_fc % ET) < D) ? oh(elem(m_fc / ET)) : 4'b0000;
    if (e2 && !m_eu && keys != 4'd0) return keys;
    return 4'b0000;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr = 16'hACE1;
      m_hist.delete();
      m_round = 0; m_score = 0; m_level = 0;
      m_fc = 0; m_tc = 0; m_press = 0;
      m_err = 0; m_ef = 0; m_eu = 0; m_et = 0;
    end else begin
      bit mt;
      mt = x_match();
      if (r1) begin
        m_hist.delete();
        m_round = 0; m_score = 0; m_level = 0;
      end
      if (r2) begin
        m_fc = 0; m_tc = 0; m_press = 0;
        m_err = 0; m_ef = 0; m_eu = 0; m_et = 0;
        if (!r1 && m_round < N - 1) m_round++;
      end else if (!r1) begin
        if (e1) begin
          m_level = int'(sw_level);
          m_hist.push_back(int'(m_lfsr[1:0]));
        end
        if (e3 && !m_ef) begin
          m_fc++;
          if (m_fc >= (m_round + 1) * ET) m_ef = 1;
        end
        if (e2) begin
          m_tc++;
          if (m_tc >= (BT >> m_level)) m_et = 1;
          if (keys != 4'd0 && !m_eu) begin
            if (keys != oh(elem(m_press))) m_err = 1;
            m_press++;
            if (m_press >= m_round + 1) m_eu = 1;
          end
        end
        if (e4 && mt && m_score < 255) m_score++;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      chk("leds",      leds,      x_leds());
      chk("end_fpga",  end_fpga,  m_ef);
      chk("end_user",  end_user,  m_eu);
      chk("end_time",  end_time,  m_et);
      chk("match",     match,     x_match());
      chk("win",       win,       (m_round == N - 1));
      chk("hex_value", hex_value, sel ? m_score : m_round + 1);
    end
  end

  // ----------------------------------------------------------------
  // Stimulus helpers
  // ----------------------------------------------------------------
  task automatic cmd(input bit a1, input bit a2, input bit s1, input bit s2, input bit s3, input bit s4);
    r1 = a1; r2 = a2; e1 = s1; e2 = s2; e3 = s3; e4 = s4;
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic game();
    int slen, plen, ulen, p;
    sel = 1'($urandom_range(0, 1));
    keys = 4'd0;
    cmd(1, 1, 0, 0, 0, 0); next_cyc();
    sw_level = 2'($urandom_range(0, 3));
    slen = $urandom_range(1, 8);
    cmd(0, 0, 1, 0, 0, 0); repeat (slen) next_cyc();
    for (int r = 0; r < N + 1; r++) begin
      plen = (m_round + 1) * ET + $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) plen = $urandom_range(1, plen);
      cmd(0, 0, 0, 0, 1, 0);
      for (int c = 0; c < plen; c++) begin
        sel  = 1'($urandom_range(0, 1));
        keys = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        next_cyc();
      end
      cmd(0, 0, 0, 0, 0, 0);
      keys = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) next_cyc();
      ulen = $urandom_range(5, 40);
      cmd(0, 0, 0, 1, 0, 0);
      for (int c = 0; c < ulen; c++) begin
        sel = 1'($urandom_range(0, 1));
        p = $urandom_range(0, 9);
        if (p < 3)       keys = oh(elem(m_press));
        else if (p == 3) keys = 4'($urandom_range(0, 15));
        else if (p == 4) keys = oh((elem(m_press) + 1) % 4);
        else             keys = 4'd0;
        next_cyc();
      end
      keys = 4'd0;
      cmd(0, 0, 0, 0, 0, 1); next_cyc();
      cmd(0, 1, 0, 0, 0, 0); next_cyc();
    end
    cmd(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ----------------------------------------------------------------
  // Main sequence
  // ----------------------------------------------------------------
  initial begin
    @(posedge clock);
    chk_on = 1;
    #1;
    @(negedge clock);
    chk("rst_leds",     leds,      4'd0);
    chk("rst_hex",      hex_value, 8'd1);
    chk("rst_end_fpga", end_fpga,  1'b0);
    chk("rst_end_user", end_user,  1'b0);
    chk("rst_end_time", end_time,  1'b0);
    chk("rst_win",      win,       1'b0);
    chk("rst_match",    match,     1'b0);
    next_cyc();

    // 1: fresh game, 3 setup cycles at level 2
    reset = 1'b0;
    cmd(1, 1, 0, 0, 0, 0); next_cyc();
    sw_level = 2'd2;
    cmd(0, 0, 1, 0, 0, 0); repeat (3) next_cyc();
    cmd(0, 0, 0, 0, 0, 0);
    // Seed ACE1 -> 59C3 -> B387 -> 670F -> CE1E; pairs taken from the middle three.
    chk("model_lfsr",  m_lfsr,       32'h0000CE1E);
    chk("model_hsize", m_hist.size(), 3);
    chk("model_e0",    elem(0),       3);
    chk("model_e2",    elem(2),       3);
    chk("model_level", m_level,       2);
    @(negedge clock);
    chk("setup_hex", hex_value, 8'd1);
    next_cyc();

    // 2: FPGA display of round 0
    cmd(0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("disp_leds",     leds,     (c < D) ? 4'b1000 : 4'b0000);
      chk("disp_end_fpga", end_fpga, (c >= ET) ? 1'b1 : 1'b0);
      next_cyc();
    end
    cmd(0, 0, 0, 0, 0, 0); next_cyc();

    // 3: correct key in round 0, then check
    cmd(0, 0, 0, 1, 0, 0);
    keys = 4'b1000;
    @(negedge clock);
    chk("u0_echo", leds,     4'b1000);
    chk("u0_eu0",  end_user, 1'b0);
    next_cyc();
    keys = 4'd0;
    @(negedge clock);
    chk("u0_eu1",   end_user, 1'b1);
    chk("u0_match", match,    1'b1);
    next_cyc();
    cmd(0, 0, 0, 0, 0, 1); next_cyc();
    cmd(0, 0, 0, 0, 0, 0);
    sel = 1'b1;
    @(negedge clock);
    chk("score1_hex", hex_value, 8'd1);
    next_cyc();
    sel = 1'b0;

    // 4: round 1, wrong then correct key
    cmd(0, 1, 0, 0, 0, 0); next_cyc();
    cmd(0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      keys = (c == 0) ? 4'b0001 : (c == 2) ? 4'b1000 : 4'b0000;
      @(negedge clock);
      if (c == 3) begin
        chk("u1_eu",    end_user,  1'b1);
        chk("u1_match", match,     1'b0);
        chk("u1_hex",   hex_value, 8'd2);
      end
      next_cyc();
    end
    keys = 4'd0;
    cmd(0, 0, 0, 0, 0, 1); next_cyc();
    cmd(0, 0, 0, 0, 0, 0);

    // 5: round 2, timeout at level 2 with last key on the limit cycle
    cmd(0, 1, 0, 0, 0, 0); next_cyc();
    cmd(0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 27; c++) begin
      keys = (c == 3 || c == 10 || c == 24) ? 4'b1000 : 4'b0000;
      @(negedge clock);
      if (c == 24) begin
        chk("t_et24", end_time, 1'b0);
        chk("t_eu24", end_user, 1'b0);
      end
      if (c == 25) begin
        chk("t_et25",    end_time, 1'b1);
        chk("t_eu25",    end_user, 1'b1);
        chk("t_match25", match,    1'b1);
      end
      next_cyc();
    end
    keys = 4'd0;
    cmd(0, 0, 0, 0, 0, 0); next_cyc();

    // 6: round saturation, win, async reset mid-play
    cmd(1, 0, 0, 0, 0, 0); next_cyc();
    cmd(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("r1_hex", hex_value, 8'd1);
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      cmd(0, 1, 0, 0, 0, 0); next_cyc();
      cmd(0, 0, 0, 0, 0, 0);
      @(negedge clock);
      chk("sat_hex", hex_value, (k < 3) ? 8'(k + 2) : 8'd4);
      chk("sat_win", win,       (k >= 2) ? 1'b1 : 1'b0);
      next_cyc();
    end
    cmd(0, 0, 0, 0, 1, 0);
    @(negedge clock);
    chk("pre_rst_leds", leds, 4'b0001);
    next_cyc();
    next_cyc();
    #2 reset = 1'b1;
    #1;
    chk("arst_leds",     leds,      4'd0);
    chk("arst_win",      win,       1'b0);
    chk("arst_hex",      hex_value, 8'd1);
    chk("arst_end_fpga", end_fpga,  1'b0);
    chk("arst_end_user", end_user,  1'b0);
    chk("arst_end_time", end_time,  1'b0);
    chk("arst_match",    match,     1'b0);
    next_cyc();
    cmd(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    next_cyc();

    // Randomized full games against the model
    for (int g = 0; g < 6; g++) game();

    repeat (2) next_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
